// File: rtl/risc8_bus_arb.sv
// Two-master external bus arbiter for the risc8 core: CPU has priority, DMA gets
// a guaranteed slot after CPU_MAX contested CPU grants, and hung transfers time out.
module risc8_bus_arb #(
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int CPU_MAX = 4,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_cpu_cycle,
    input  logic          i_cpu_write,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic          o_cpu_ready,
    output logic [DW-1:0] o_cpu_rdata,
    input  logic          i_dma_req,
    input  logic          i_dma_write,
    input  logic [AW-1:0] i_dma_addr,
    input  logic [DW-1:0] i_dma_wdata,
    output logic          o_dma_ack,
    output logic [DW-1:0] o_dma_rdata,
    output logic          o_mem_cycle,
    output logic          o_mem_write,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic          i_mem_ready,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_bus_err,
    input  logic          i_err_clr,
    output logic          o_owner
);

    localparam int RUN_W  = $clog2(CPU_MAX + 1);
    localparam int WAIT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, CPU_XFER, DMA_XFER} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [RUN_W-1:0]    r_cpu_run;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_bus_err;

    logic                w_xfer;
    logic                w_timeout;
    logic                w_done;
    logic                w_grant_dma;
    logic [DW-1:0]       w_rdata;

    assign w_xfer      = (r_state != IDLE);
    assign w_timeout   = w_xfer && !i_mem_ready && (r_wait_cnt == WAIT_W'(TIMEOUT - 1));
    assign w_done      = w_xfer && (i_mem_ready || w_timeout);
    // DMA wins a contested slot only once the CPU has used up its run allowance
    assign w_grant_dma = i_dma_req && (!i_cpu_cycle || (r_cpu_run == RUN_W'(CPU_MAX)));
    assign w_rdata     = w_timeout ? {DW{1'b1}} : i_mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_dma) begin
                    w_state_next = DMA_XFER;
                end else if (i_cpu_cycle) begin
                    w_state_next = CPU_XFER;
                end
            end
            CPU_XFER, DMA_XFER: begin
                if (w_done) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        o_mem_cycle = 1'b0;
        o_mem_write = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_owner     = 1'b0;
        o_cpu_ready = 1'b0;
        o_cpu_rdata = '0;
        o_dma_ack   = 1'b0;
        o_dma_rdata = '0;
        case (r_state)
            CPU_XFER: begin
                o_mem_cycle = 1'b1;
                o_mem_write = i_cpu_write;
                o_mem_addr  = i_cpu_addr;
                o_mem_wdata = i_cpu_wdata;
                o_cpu_ready = w_done;
                o_cpu_rdata = w_done ? w_rdata : '0;
            end
            DMA_XFER: begin
                o_mem_cycle = 1'b1;
                o_mem_write = i_dma_write;
                o_mem_addr  = i_dma_addr;
                o_mem_wdata = i_dma_wdata;
                o_owner     = 1'b1;
                o_dma_ack   = w_done;
                o_dma_rdata = w_done ? w_rdata : '0;
            end
            default: ;
        endcase
    end

    // Run counter tracks contested CPU grants; wait counter restarts in every IDLE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpu_run  <= '0;
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_wait_cnt <= '0;
                if (w_grant_dma) begin
                    r_cpu_run <= '0;
                end else if (i_cpu_cycle) begin
                    if (!i_dma_req) begin
                        r_cpu_run <= '0;
                    end else if (r_cpu_run != RUN_W'(CPU_MAX)) begin
                        r_cpu_run <= r_cpu_run + RUN_W'(1);
                    end
                end
            end else if (!i_mem_ready) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end else if (i_err_clr) begin
                r_bus_err <= 1'b0;
            end
        end
    end

    assign o_bus_err = r_bus_err;

endmodule

// File: tb/tb_risc8_bus_arb.sv
// Directed bench for risc8_bus_arb: reset, CPU read, fairness, timeout, late ready
// and reset in the middle of a transfer.
module tb_risc8_bus_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_cycle, cpu_write, cpu_ready;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        dma_req, dma_write, dma_ack;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata, dma_rdata;
    logic        mem_cycle, mem_write, mem_ready;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        bus_err, err_clr, owner;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    risc8_bus_arb #(.AW(16), .DW(8), .CPU_MAX(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .i_cpu_cycle(cpu_cycle), .i_cpu_write(cpu_write), .i_cpu_addr(cpu_addr),
        .i_cpu_wdata(cpu_wdata), .o_cpu_ready(cpu_ready), .o_cpu_rdata(cpu_rdata),
        .i_dma_req(dma_req), .i_dma_write(dma_write), .i_dma_addr(dma_addr),
        .i_dma_wdata(dma_wdata), .o_dma_ack(dma_ack), .o_dma_rdata(dma_rdata),
        .o_mem_cycle(mem_cycle), .o_mem_write(mem_write), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
        .o_bus_err(bus_err), .i_err_clr(err_clr), .o_owner(owner)
    );

    task automatic clear_inputs();
        cpu_cycle = 0; cpu_write = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_write = 0; dma_addr = '0; dma_wdata = '0;
        mem_ready = 0; mem_rdata = '0; err_clr = 0;
    endtask

    task automatic test_reset();
        logic [45:0] obs;
        rst = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            {cpu_cycle, cpu_write, dma_req, dma_write, mem_ready, err_clr} = 6'($urandom);
            cpu_addr = 16'($urandom); dma_addr = 16'($urandom); mem_rdata = 8'($urandom);
            cpu_wdata = 8'($urandom); dma_wdata = 8'($urandom);
            @(negedge clk);
            obs = {cpu_ready, cpu_rdata, dma_ack, dma_rdata, mem_cycle, mem_write,
                   mem_addr, mem_wdata, bus_err, owner};
            checks++;
            if (obs !== 46'd0) $display("FAIL reset_outputs cycle %0d got %h exp 0", i, obs);
            else passes++;
        end
        clear_inputs();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mem_cycle !== 1'b0) $display("FAIL reset_idle cycle %0d mem_cycle got %b exp 0", i, mem_cycle);
            else passes++;
        end
    endtask

    task automatic test_cpu_read();
        @(negedge clk);
        cpu_cycle = 1; cpu_write = 0; cpu_addr = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_cycle, mem_write, mem_addr, owner, cpu_ready} !== {1'b1, 1'b0, 16'h1234, 1'b0, 1'b0})
            $display("FAIL cpu_read_grant got cyc=%b wr=%b addr=%h own=%b rdy=%b exp 1 0 1234 0 0",
                     mem_cycle, mem_write, mem_addr, owner, cpu_ready);
        else passes++;
        @(negedge clk);
        checks++;
        if ({mem_cycle, cpu_ready} !== 2'b10)
            $display("FAIL cpu_read_wait got cyc=%b rdy=%b exp 1 0", mem_cycle, cpu_ready);
        else passes++;
        @(posedge clk); #1;
        mem_ready = 1; mem_rdata = 8'hA5;
        @(negedge clk);
        checks++;
        if ({cpu_ready, cpu_rdata, dma_ack} !== {1'b1, 8'hA5, 1'b0})
            $display("FAIL cpu_read_done got rdy=%b rdata=%h ack=%b exp 1 a5 0", cpu_ready, cpu_rdata, dma_ack);
        else passes++;
        @(posedge clk); #1;
        cpu_cycle = 0; mem_ready = 0; mem_rdata = '0;
        @(negedge clk);
        checks++;
        if ({mem_cycle, cpu_ready, cpu_rdata} !== 10'd0)
            $display("FAIL cpu_read_turnaround got cyc=%b rdy=%b rdata=%h exp 0 0 00", mem_cycle, cpu_ready, cpu_rdata);
        else passes++;
    endtask

    task automatic test_fairness();
        logic [9:0] exp_seq;
        exp_seq = 10'b10_0001_0000;  // bit i = 1 means grant i goes to DMA
        @(negedge clk);
        cpu_cycle = 1; cpu_addr = 16'h0100; dma_req = 1; dma_addr = 16'h0200;
        mem_ready = 1; mem_rdata = 8'h77;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (i % 2 == 0) begin
                if ({mem_cycle, owner, cpu_ready, dma_ack} !==
                    {1'b1, exp_seq[i/2], !exp_seq[i/2], exp_seq[i/2]})
                    $display("FAIL fair_grant %0d got cyc=%b own=%b rdy=%b ack=%b exp own=%b",
                             i / 2, mem_cycle, owner, cpu_ready, dma_ack, exp_seq[i/2]);
                else passes++;
            end else begin
                if (mem_cycle !== 1'b0)
                    $display("FAIL fair_turnaround %0d mem_cycle got %b exp 0", i / 2, mem_cycle);
                else passes++;
            end
        end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_timeout();
        @(negedge clk);
        dma_req = 1; dma_write = 1; dma_addr = 16'hABCD; dma_wdata = 8'h3C;
        @(posedge clk);
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if ({mem_cycle, mem_write, mem_addr, mem_wdata, owner} !== {1'b1, 1'b1, 16'hABCD, 8'h3C, 1'b1})
                    $display("FAIL dma_write_bus got cyc=%b wr=%b addr=%h wd=%h own=%b exp 1 1 abcd 3c 1",
                             mem_cycle, mem_write, mem_addr, mem_wdata, owner);
                else passes++;
            end
            if (k == 63) begin
                checks++;
                if ({dma_ack, mem_cycle} !== 2'b01)
                    $display("FAIL timeout_early got ack=%b cyc=%b exp 0 1 at cycle 63", dma_ack, mem_cycle);
                else passes++;
            end
            if (k == 64) begin
                checks++;
                if ({dma_ack, dma_rdata, bus_err, cpu_ready} !== {1'b1, 8'hFF, 1'b0, 1'b0})
                    $display("FAIL timeout_strobe got ack=%b rdata=%h err=%b rdy=%b exp 1 ff 0 0",
                             dma_ack, dma_rdata, bus_err, cpu_ready);
                else passes++;
            end
        end
        @(posedge clk); #1;
        dma_req = 0;
        @(negedge clk);
        checks++;
        if ({bus_err, mem_cycle, dma_ack} !== 3'b100)
            $display("FAIL timeout_err_set got err=%b cyc=%b ack=%b exp 1 0 0", bus_err, mem_cycle, dma_ack);
        else passes++;
        @(negedge clk);
        checks++;
        if (bus_err !== 1'b1) $display("FAIL err_sticky got %b exp 1", bus_err);
        else passes++;
        err_clr = 1;
        @(posedge clk); #1;
        err_clr = 0;
        @(negedge clk);
        checks++;
        if (bus_err !== 1'b0) $display("FAIL err_clear got %b exp 0", bus_err);
        else passes++;
    endtask

    task automatic test_late_ready();
        @(negedge clk);
        cpu_cycle = 1; cpu_addr = 16'h4444;
        @(posedge clk); #1;
        for (int k = 1; k <= 64; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (k == 64) begin
                mem_ready = 1; mem_rdata = 8'h5A;
            end
            @(negedge clk);
        end
        checks++;
        if ({cpu_ready, cpu_rdata, bus_err} !== {1'b1, 8'h5A, 1'b0})
            $display("FAIL late_ready_done got rdy=%b rdata=%h err=%b exp 1 5a 0", cpu_ready, cpu_rdata, bus_err);
        else passes++;
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({bus_err, mem_cycle} !== 2'b00)
            $display("FAIL late_ready_no_err got err=%b cyc=%b exp 0 0", bus_err, mem_cycle);
        else passes++;
    endtask

    task automatic test_reset_mid_xfer();
        logic saw_ready;
        saw_ready = 0;
        @(negedge clk);
        cpu_cycle = 1; cpu_addr = 16'h0BAD;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_cycle !== 1'b1) $display("FAIL rst_mid_grant mem_cycle got %b exp 1", mem_cycle);
        else passes++;
        #2;
        rst = 1;
        mem_ready = 1;
        #1;
        checks++;
        if ({mem_cycle, cpu_ready, owner} !== 3'b000)
            $display("FAIL rst_async got cyc=%b rdy=%b own=%b exp 0 0 0", mem_cycle, cpu_ready, owner);
        else passes++;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (cpu_ready) saw_ready = 1;
        end
        @(negedge clk);
        rst = 0;
        mem_ready = 0;
        #1;
        checks++;
        if ({saw_ready, cpu_ready, mem_cycle} !== 3'b000)
            $display("FAIL rst_no_strobe got saw=%b rdy=%b cyc=%b exp 0 0 0", saw_ready, cpu_ready, mem_cycle);
        else passes++;
        @(negedge clk);
        checks++;
        if ({mem_cycle, owner, mem_addr} !== {1'b1, 1'b0, 16'h0BAD})
            $display("FAIL rst_regrant got cyc=%b own=%b addr=%h exp 1 0 0bad", mem_cycle, owner, mem_addr);
        else passes++;
        @(posedge clk); #1;
        mem_ready = 1; mem_rdata = 8'h11;
        @(negedge clk);
        checks++;
        if ({cpu_ready, cpu_rdata} !== {1'b1, 8'h11})
            $display("FAIL rst_regrant_done got rdy=%b rdata=%h exp 1 11", cpu_ready, cpu_rdata);
        else passes++;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before bench completed");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_cpu_read();
        test_fairness();
        test_timeout();
        test_late_ready();
        test_reset_mid_xfer();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/risc8_bus_arb.md
Name: risc8_bus_arb

Overview:
- Two-master arbiter for the external memory bus of the risc8 core: master 0 is the CPU bus interface (cycle/write/address/data_out/ready), master 1 is a DMA engine.
- Sits between the core's bus pins and the memory/peripheral fabric.
- Grants one transfer at a time, gives the CPU priority with a starvation guard for DMA, and terminates hung transfers with a timeout and error flag.

Parameters:
- AW, 16, address width.
- DW, 8, data width.
- CPU_MAX, 4, consecutive CPU grants allowed while DMA is pending before DMA must be granted (>=1).
- TIMEOUT, 64, cycles a granted transfer may wait for mem_ready before forced termination (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- cpu_cycle  in  1  CPU bus cycle request; held until completion.
- cpu_write  in  1  CPU write cycle.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_ready  out  1  completion strobe to CPU (drives core ready).
- cpu_rdata  out  DW  read data to CPU.
- dma_req  in  1  DMA transfer request; held until dma_ack.
- dma_write  in  1  DMA write.
- dma_addr  in  AW  DMA address.
- dma_wdata  in  DW  DMA write data.
- dma_ack  out  1  completion strobe to DMA.
- dma_rdata  out  DW  read data to DMA.
- mem_cycle  out  1  bus cycle to memory.
- mem_write  out  1  write qualifier.
- mem_addr  out  AW  address to memory.
- mem_wdata  out  DW  write data to memory.
- mem_ready  in  1  memory completion.
- mem_rdata  in  DW  memory read data.
- bus_err  out  1  sticky timeout flag.
- err_clr  in  1  clears bus_err.
- owner  out  1  current owner (0 CPU, 1 DMA); valid while mem_cycle=1.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port rst.
- FSM states: IDLE, CPU_XFER, DMA_XFER. Reset to IDLE.
- Reset values: all outputs 0; internal counters 0.
- IDLE arbitration, registered, 1-cycle latency:
  - cpu_cycle only -> CPU_XFER.
  - dma_req only -> DMA_XFER.
  - Both -> DMA_XFER if cpu_run==CPU_MAX, else CPU_XFER.
  - Neither -> stay in IDLE.
- Request-to-bus timing: a request sampled in IDLE at edge N drives mem_cycle=1 from cycle N+1.
- In XFER states, mem_cycle=1 and mem_write/mem_addr/mem_wdata are combinationally muxed from the owner. In IDLE, mem_cycle=mem_write=0 and mem_addr/mem_wdata=0.
- Completion is mem_ready=1 in an XFER state:
  - cpu_ready (or dma_ack) =1 in that same cycle.
  - The owner's rdata equals mem_rdata.
  - Next state is IDLE, giving a mandatory 1-cycle turnaround; no back-to-back grants.
- cpu_ready/dma_ack are 0 whenever that master is not the owner. rdata outputs are 0 when not completing.
- cpu_run counter, saturating at CPU_MAX:
  - +1 on each CPU grant made while dma_req=1.
  - Cleared on any DMA grant.
  - Cleared on a CPU grant while dma_req=0.
- Timeout:
  - wait_cnt clears on entry to an XFER state and increments each XFER cycle with mem_ready=0.
  - When wait_cnt==TIMEOUT-1 and mem_ready=0, the transfer is force-terminated: the owner's strobe =1, rdata=all ones, and the next state is IDLE.
  - bus_err sets on the following edge.
  - If mem_ready=1 arrives in the timeout cycle, it is a normal completion with no error.
- bus_err is sticky until err_clr=1. If err_clr and a new timeout occur in the same cycle, set wins.
- Requester dropping its request mid-transfer: protocol violation. The arbiter completes the transfer anyway on mem_ready/timeout.
- rst asserted mid-transfer: immediately IDLE, mem_cycle=0, strobes 0, counters 0, bus_err 0.

Test Plan:
- Reset: rst=1 with random inputs -> all outputs 0; after release with no requests, mem_cycle stays 0.
- CPU read: cpu_cycle=1, addr 16'h1234 at edge N -> mem_cycle=1, mem_addr=16'h1234 from N+1; memory ready on N+3 with rdata 8'hA5 -> cpu_ready=1 and cpu_rdata=8'hA5 that cycle; mem_cycle=0 at N+4.
- Fairness: cpu_cycle and dma_req held continuously, mem_ready=1 each XFER cycle, CPU_MAX=4 -> grant sequence C,C,C,C,D,C,C,C,C,D; every grant followed by one IDLE cycle.
- Timeout: DMA write granted, mem_ready held 0 -> dma_ack=1 in the 64th XFER cycle, dma_rdata=8'hFF, bus_err=1 next cycle; err_clr pulse -> bus_err=0.
- Late ready: mem_ready=1 exactly in the 64th XFER cycle -> normal completion, bus_err stays 0.
- Reset mid-transfer: rst pulsed during CPU_XFER -> mem_cycle=0 asynchronously, cpu_ready never pulses; after release, the pending cpu_cycle is re-granted with 1-cycle latency.
